fir_frame_collector: RTL

- Sits directly downstream of the 32-tap FIR stage.
- Captures the FIR output stream (fir_valid/fir_d) into 16-sample frames for the 16-point FFT stage.
- Double-buffered (ping-pong): one bank fills while the other is held for the FFT.
- Exposes each full frame in parallel behind a valid/ready handshake, and flags overflow when the FFT falls behind.

---
 rtl/fft_frame_pkg.sv | 8 +
 rtl/fir_frame_collector_if.sv | 26 ++
 rtl/frame_bank.sv | 19 +
 rtl/fir_frame_collector.sv | 88 ++++++++
 4 files changed

// File: rtl/fft_frame_pkg.sv
// Shared frame geometry and frame type for the FIR-to-FFT path.
// Slice 0 of a frame is the oldest sample.
package fft_frame_pkg;
  localparam int N_SAMP = 16;
  localparam int DW = 16;
  localparam int IDX_W = $clog2(N_SAMP);
  typedef logic [N_SAMP-1:0][DW-1:0] frame_t;
endpackage

// File: rtl/fir_frame_collector_if.sv
// Sample stream in, frame handshake out, overflow status.
// The collector is the slave; its driver/consumer is the master.
interface fir_frame_collector_if #(
  parameter int CNT_W = 8
);
  import fft_frame_pkg::*;
  logic             fir_valid;
  logic [DW-1:0]    fir_d;
  logic             frm_valid;
  logic             frm_ready;
  frame_t           frm_data;
  logic             frm_bank;
  logic             ovf;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output fir_valid, fir_d, frm_ready,
    input  frm_valid, frm_data, frm_bank,
    input  ovf, drop_cnt
  );
  modport slave (
    input  fir_valid, fir_d, frm_ready,
    output frm_valid, frm_data, frm_bank,
    output ovf, drop_cnt
  );
endinterface

// File: rtl/frame_bank.sv
// One frame of sample storage: indexed write, parallel read.
// Contents are deliberately left unreset.
module frame_bank
  import fft_frame_pkg::*;
(
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [DW-1:0]    i_d,
  output frame_t           o_frame
);
  frame_t r_mem;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= i_d;
  end

  assign o_frame = r_mem;
endmodule

// File: rtl/fir_frame_collector.sv
// Ping-pong collector: FIR samples into frames for the FFT.
// Fullness is judged on registered flags only, no bypass.
module fir_frame_collector
  import fft_frame_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  fir_frame_collector_if.slave bus
);
  logic             r_wr_bank;
  logic [IDX_W-1:0] r_wr_idx;
  logic [1:0]       r_full;
  logic             r_rd_bank;
  logic             r_ovf;
  logic [CNT_W-1:0] r_drop_cnt;

  logic       w_accept;
  logic       w_drop;
  logic       w_last;
  logic       w_hs;
  logic [1:0] w_full_nxt;
  frame_t     w_frame0;
  frame_t     w_frame1;

  assign w_accept = bus.fir_valid & ~r_full[r_wr_bank];
  assign w_drop   = bus.fir_valid &  r_full[r_wr_bank];
  assign w_last   = w_accept &
                    (r_wr_idx == IDX_W'(N_SAMP - 1));
  assign w_hs     = r_full[r_rd_bank] & bus.frm_ready;

  // A bank cannot be both filled and released on one edge
  always_comb begin
    w_full_nxt = r_full;
    if (w_last) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_hs)   w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_bank  <= 1'b0;
      r_wr_idx   <= '0;
      r_full     <= 2'b00;
      r_rd_bank  <= 1'b0;
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_accept) begin
        if (w_last) begin
          r_wr_idx  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_idx <= r_wr_idx + 1'b1;
        end
      end
      r_full <= w_full_nxt;
      if (w_hs) r_rd_bank <= ~r_rd_bank;
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop_cnt != '1)
          r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  frame_bank u_bank0 (
    .clk     (clk),
    .i_we    (w_accept & ~r_wr_bank),
    .i_idx   (r_wr_idx),
    .i_d     (bus.fir_d),
    .o_frame (w_frame0)
  );

  frame_bank u_bank1 (
    .clk     (clk),
    .i_we    (w_accept & r_wr_bank),
    .i_idx   (r_wr_idx),
    .i_d     (bus.fir_d),
    .o_frame (w_frame1)
  );

  assign bus.frm_valid = r_full[r_rd_bank];
  assign bus.frm_data  = r_rd_bank ? w_frame1 : w_frame0;
  assign bus.frm_bank  = r_rd_bank;
  assign bus.ovf       = r_ovf;
  assign bus.drop_cnt  = r_drop_cnt;
endmodule
